// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Memory-side responder for the instruction and data caches.
//               It shares one single-port RAM between icache reads and dcache
//               reads/writes, and returns data with a one-cycle wait-low
//               handshake per master. The dcache has priority. A streak
//               counter bounds how long a pending icache read can be
//               starved. An access timer aborts accesses to a hung RAM.
// Ports       : CLK, RST                    clock, synchronous active-high reset
//               iREN, iaddr                 icache read request
//               dREN, dWEN, daddr, dstore   dcache read/write request
//               iwait, iload                icache completion pulse and data
//               dwait, dload                dcache completion pulse and data
//               ramREN, ramWEN, ramaddr,
//               ramstore                    RAM command (all registered)
//               ramload, ram_ready          RAM read data and completion pulse
//               bus_err                     sticky error flag
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int RAM_TIMEOUT  = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_ready,
    output logic              bus_err
);

    localparam int c_SW = $clog2(MAX_D_STREAK + 1);
    // The timer only has to reach RAM_TIMEOUT-1 before the access is abandoned.
    localparam int c_TW = (RAM_TIMEOUT > 1) ? $clog2(RAM_TIMEOUT) : 1;

    localparam logic [c_SW-1:0]   c_STREAK_MAX = c_SW'(MAX_D_STREAK);
    localparam logic [c_TW-1:0]   c_TIMER_LAST = c_TW'(RAM_TIMEOUT - 1);
    localparam logic [DATA_W-1:0] c_BAD_DATA   = DATA_W'(32'hBAD1_BAD1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic              r_owner_d;   // 1: dcache owns the current access
    logic              r_write;     // current access is a dcache write
    logic [c_SW-1:0]   r_streak;
    logic [c_TW-1:0]   r_timer;
    logic              r_iwait;
    logic              r_dwait;
    logic [DATA_W-1:0] r_iload;
    logic [DATA_W-1:0] r_dload;
    logic              r_ramren;
    logic              r_ramwen;
    logic [ADDR_W-1:0] r_ramaddr;
    logic [DATA_W-1:0] r_ramstore;
    logic              r_bus_err;

    logic              w_d_req;
    logic              w_d_grant;
    logic              w_i_grant;
    logic              w_timeout;
    logic              w_done;
    logic [DATA_W-1:0] w_load_val;

    assign w_d_req    = dREN | dWEN;
    assign w_load_val = ram_ready ? ramload : c_BAD_DATA;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Grant decision and next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_d_grant   = 1'b0;
        w_i_grant   = 1'b0;
        w_timeout   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // dcache wins unless it has already starved a waiting icache
                // for MAX_D_STREAK grants in a row.
                w_d_grant = w_d_req && (!iREN || (r_streak < c_STREAK_MAX));
                w_i_grant = !w_d_grant && iREN;
                if (w_d_grant || w_i_grant) begin
                    w_state_nxt = c_ST_ACCESS;
                end
            end
            c_ST_ACCESS: begin
                w_timeout = !ram_ready && (r_timer == c_TIMER_LAST);
                w_done    = ram_ready || w_timeout;
                if (w_done) begin
                    w_state_nxt = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                // Mandatory bubble: a request held through RESP is only seen
                // again in the following IDLE cycle.
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered datapath and outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_owner_d  <= 1'b0;
            r_write    <= 1'b0;
            r_streak   <= '0;
            r_timer    <= '0;
            r_iwait    <= 1'b1;
            r_dwait    <= 1'b1;
            r_iload    <= '0;
            r_dload    <= '0;
            r_ramren   <= 1'b0;
            r_ramwen   <= 1'b0;
            r_ramaddr  <= '0;
            r_ramstore <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            // Waits are single-cycle pulses; they fall back high by default.
            r_iwait <= 1'b1;
            r_dwait <= 1'b1;
            case (r_state)
                c_ST_IDLE: begin
                    r_timer <= '0;
                    if (w_d_grant) begin
                        r_owner_d  <= 1'b1;
                        r_write    <= dWEN;
                        r_ramaddr  <= daddr;
                        r_ramstore <= dstore;
                        r_ramren   <= !dWEN;
                        r_ramwen   <= dWEN;
                        if (dREN && dWEN) begin
                            r_bus_err <= 1'b1;
                        end
                        if (iREN) begin
                            if (r_streak != c_STREAK_MAX) begin
                                r_streak <= r_streak + c_SW'(1);
                            end
                        end else begin
                            r_streak <= '0;
                        end
                    end else if (w_i_grant) begin
                        r_owner_d <= 1'b0;
                        r_write   <= 1'b0;
                        r_ramaddr <= iaddr;
                        r_ramren  <= 1'b1;
                        r_ramwen  <= 1'b0;
                        r_streak  <= '0;
                    end
                end
                c_ST_ACCESS: begin
                    r_timer <= r_timer + c_TW'(1);
                    if (w_done) begin
                        r_ramren <= 1'b0;
                        r_ramwen <= 1'b0;
                        if (w_timeout) begin
                            r_bus_err <= 1'b1;
                        end
                        if (r_owner_d) begin
                            r_dwait <= 1'b0;
                            if (!r_write) begin
                                r_dload <= w_load_val;
                            end
                        end else begin
                            r_iwait <= 1'b0;
                            r_iload <= w_load_val;
                        end
                    end
                end
                default: begin
                    r_ramren <= 1'b0;
                    r_ramwen <= 1'b0;
                end
            endcase
        end
    end

    assign iwait    = r_iwait;
    assign dwait    = r_dwait;
    assign iload    = r_iload;
    assign dload    = r_dload;
    assign ramREN   = r_ramren;
    assign ramWEN   = r_ramwen;
    assign ramaddr  = r_ramaddr;
    assign ramstore = r_ramstore;
    assign bus_err  = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_memory_arbiter
// Description : Self-checking bench for memory_arbiter: directed scenarios
//               followed by randomized traffic against a transaction-level
//               model (grant time + RAM delay arithmetic).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          iREN = 1'b0;
    logic [AW-1:0] iaddr = '0;
    logic          dREN = 1'b0;
    logic          dWEN = 1'b0;
    logic [AW-1:0] daddr = '0;
    logic [DW-1:0] dstore = '0;
    logic [DW-1:0] ramload = '0;
    logic          ram_ready = 1'b0;
    logic          iwait;
    logic [DW-1:0] iload;
    logic          dwait;
    logic [DW-1:0] dload;
    logic          ramREN;
    logic          ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore;
    logic          bus_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [logic [31:0]];

    memory_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MAX_D_STREAK(MAXS),
        .RAM_TIMEOUT (TMO)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .iwait    (iwait),
        .iload    (iload),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ram_ready(ram_ready)
        ,.bus_err (bus_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return ~a;
    endfunction

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) tick();
        total++;
        if ({iwait, dwait} !== 2'b11) begin
            bad++; $display("FAIL reset_waits: got %b want 11", {iwait, dwait});
        end
        total++;
        if ({iload, dload} !== 64'h0) begin
            bad++; $display("FAIL reset_loads: got %h/%h want 0/0", iload, dload);
        end
        total++;
        if ({ramREN, ramWEN, ramaddr, ramstore} !== 66'h0) begin
            bad++; $display("FAIL reset_ram: got ren=%b wen=%b a=%h s=%h want all 0", ramREN, ramWEN, ramaddr, ramstore);
        end
        total++;
        if (bus_err !== 1'b0) begin
            bad++; $display("FAIL reset_bus_err: got %b want 0", bus_err);
        end
        RST = 1'b0;
        tick();
        total++;
        if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
            bad++; $display("FAIL idle_after_reset: got %b want 0011", {ramREN, ramWEN, iwait, dwait});
        end
    endtask

    task automatic test_i_read();
        iREN = 1'b1; iaddr = 32'h40;                 // cycle 0
        tick();
        iREN = 1'b0; iaddr = 32'hFFFF_0000;          // dropped/changed: must be ignored
        for (int c = 1; c <= 3; c++) begin
            total++;
            if ({ramREN, ramWEN, ramaddr, iwait, dwait} !== {1'b1, 1'b0, 32'h40, 2'b11}) begin
                bad++; $display("FAIL i_read_access c%0d: got ren=%b wen=%b a=%h w=%b%b want 1 0 40 11",
                                c, ramREN, ramWEN, ramaddr, iwait, dwait);
            end
            if (c == 3) begin ram_ready = 1'b1; ramload = 32'hDEAD_BEEF; end
            else        begin ramload = $urandom; end
            tick();
        end
        ram_ready = 1'b0; ramload = $urandom;        // cycle 4
        total++;
        if ({iwait, dwait, ramREN, ramWEN} !== 4'b0100) begin
            bad++; $display("FAIL i_read_resp: got iw=%b dw=%b ren=%b wen=%b want 0 1 0 0", iwait, dwait, ramREN, ramWEN);
        end
        total++;
        if (iload !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL i_read_data: got %h want deadbeef", iload);
        end
        tick();                                      // cycle 5
        total++;
        if ({iwait, dwait, iload} !== {2'b11, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL i_read_hold: got w=%b%b load=%h want 11 deadbeef", iwait, dwait, iload);
        end
    endtask

    task automatic test_contention();
        iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; daddr = 32'h300;   // cycle 0
        tick();                                                        // cycle 1
        total++;
        if ({ramREN, ramaddr} !== {1'b1, 32'h300}) begin
            bad++; $display("FAIL contention_d_first: got ren=%b a=%h want 1 300", ramREN, ramaddr);
        end
        ram_ready = 1'b1; ramload = 32'h1111_1111;
        tick();                                                        // cycle 2
        ram_ready = 1'b0; dREN = 1'b0;
        total++;
        if ({iwait, dwait, dload} !== {2'b10, 32'h1111_1111}) begin
            bad++; $display("FAIL contention_d_resp: got w=%b%b dload=%h want 10 11111111", iwait, dwait, dload);
        end
        tick();                                                        // cycle 3: bubble
        total++;
        if ({ramREN, ramWEN} !== 2'b00) begin
            bad++; $display("FAIL contention_bubble: got %b want 00", {ramREN, ramWEN});
        end
        tick();                                                        // cycle 4
        total++;
        if ({ramREN, ramaddr} !== {1'b1, 32'h200}) begin
            bad++; $display("FAIL contention_i_next: got ren=%b a=%h want 1 200", ramREN, ramaddr);
        end
        ram_ready = 1'b1; ramload = 32'h2222_2222;
        tick();                                                        // cycle 5
        ram_ready = 1'b0; iREN = 1'b0;
        total++;
        if ({iwait, dwait, iload} !== {2'b01, 32'h2222_2222}) begin
            bad++; $display("FAIL contention_i_resp: got w=%b%b iload=%h want 01 22222222", iwait, dwait, iload);
        end
        tick();
    endtask

    task automatic test_starvation();
        bit exp_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        int n = 0;
        dREN = 1'b1; daddr = 32'h500; iREN = 1'b1; iaddr = 32'h600;
        for (int cyc = 0; cyc < 200 && n < 10; cyc++) begin
            if (!iwait || !dwait) begin
                total++;
                if ({iwait, dwait} !== (exp_d[n] ? 2'b10 : 2'b01)) begin
                    bad++; $display("FAIL starvation_order #%0d: got w=%b%b want %s", n, iwait, dwait,
                                    exp_d[n] ? "D" : "I");
                end
                n++;
                if (n == 10) begin iREN = 1'b0; dREN = 1'b0; end
            end
            ram_ready = ramREN | ramWEN;
            ramload   = $urandom;
            tick();
        end
        ram_ready = 1'b0;
        if (n < 10) begin
            total++; bad++;
            $display("FAIL starvation_budget: got %0d completions want 10", n);
        end
        tick();
    endtask

    task automatic test_write();
        int pulses = 0;
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'h1234_5678;          // cycle 0
        tick();                                                        // cycle 1
        dWEN = 1'b0; daddr = 32'h0; dstore = 32'hFFFF_FFFF;
        for (int c = 1; c <= 2; c++) begin
            total++;
            if ({ramREN, ramWEN, ramaddr, ramstore} !== {1'b0, 1'b1, 32'h100, 32'h1234_5678}) begin
                bad++; $display("FAIL write_cmd c%0d: got ren=%b wen=%b a=%h s=%h want 0 1 100 12345678",
                                c, ramREN, ramWEN, ramaddr, ramstore);
            end
            ram_ready = (c == 2);
            tick();
        end
        ram_ready = 1'b0;                                              // cycle 3
        total++;
        if ({iwait, dwait} !== 2'b10) begin
            bad++; $display("FAIL write_resp: got w=%b%b want 10", iwait, dwait);
        end
        for (int c = 3; c < 9; c++) begin
            if (!dwait) pulses++;
            tick();
        end
        total++;
        if (pulses != 1) begin
            bad++; $display("FAIL write_pulses: got %0d want 1", pulses);
        end
        total++;
        if (bus_err !== 1'b0) begin
            bad++; $display("FAIL write_bus_err: got %b want 0", bus_err);
        end
    endtask

    task automatic test_timeout();
        dREN = 1'b1; daddr = 32'h80;                                   // cycle 0
        tick();
        dREN = 1'b0;
        for (int c = 1; c <= TMO; c++) begin
            total++;
            if ({ramREN, dwait} !== 2'b11) begin
                bad++; $display("FAIL timeout_access c%0d: got ren=%b dw=%b want 1 1", c, ramREN, dwait);
            end
            tick();
        end
        total++;                                                       // cycle TMO+1
        if ({iwait, dwait, dload, bus_err} !== {2'b10, 32'hBAD1_BAD1, 1'b1}) begin
            bad++; $display("FAIL timeout_resp: got w=%b%b dload=%h err=%b want 10 bad1bad1 1",
                            iwait, dwait, dload, bus_err);
        end
        tick();
        iREN = 1'b1; iaddr = 32'h44;
        tick();
        iREN = 1'b0; ram_ready = 1'b1; ramload = 32'h0BAD_F00D;
        tick();
        ram_ready = 1'b0;
        total++;
        if ({iwait, iload, bus_err} !== {1'b0, 32'h0BAD_F00D, 1'b1}) begin
            bad++; $display("FAIL timeout_sticky: got iw=%b iload=%h err=%b want 0 0badf00d 1", iwait, iload, bus_err);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        iREN = 1'b1; iaddr = 32'h70;
        tick();
        iREN = 1'b0;
        tick();
        total++;
        if (ramREN !== 1'b1) begin
            bad++; $display("FAIL rst_mid_pre: got ren=%b want 1", ramREN);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        total++;
        if ({ramREN, iwait, dwait, bus_err} !== 4'b0110) begin
            bad++; $display("FAIL rst_mid_abort: got %b want 0110", {ramREN, iwait, dwait, bus_err});
        end
        iREN = 1'b1; iaddr = 32'h74;
        tick();
        iREN = 1'b0;
        total++;
        if ({ramREN, ramaddr} !== {1'b1, 32'h74}) begin
            bad++; $display("FAIL rst_mid_regrant: got ren=%b a=%h want 1 74", ramREN, ramaddr);
        end
        ram_ready = 1'b1; ramload = 32'h5555_AAAA;
        tick();
        ram_ready = 1'b0;
        total++;
        if ({iwait, iload} !== {1'b0, 32'h5555_AAAA}) begin
            bad++; $display("FAIL rst_mid_min_latency: got iw=%b iload=%h want 0 5555aaaa", iwait, iload);
        end
        tick();
    endtask

    task automatic test_both_err();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h120; dstore = 32'hCAFE_F00D;
        tick();
        dREN = 1'b0; dWEN = 1'b0;
        total++;
        if ({ramREN, ramWEN, ramstore, bus_err} !== {2'b01, 32'hCAFE_F00D, 1'b1}) begin
            bad++; $display("FAIL both_err: got ren=%b wen=%b s=%h err=%b want 0 1 cafef00d 1",
                            ramREN, ramWEN, ramstore, bus_err);
        end
        ram_ready = 1'b1;
        tick();
        ram_ready = 1'b0;
        total++;
        if ({iwait, dwait} !== 2'b10) begin
            bad++; $display("FAIL both_err_resp: got w=%b%b want 10", iwait, dwait);
        end
        tick();
    endtask

    // Transaction-level model: an access granted in cycle t with RAM delay k
    // drives the RAM during t+1..t+k and pulses its owner's wait at t+k+1;
    // the next grant can be made at t+k+2.
    task automatic test_random();
        bit          i_req = 0, d_req = 0, d_w = 0;
        logic [31:0] i_a = 0, d_a = 0, d_st = 0;
        bit          busy = 0, own_d = 0, w = 0;
        int          t_g = 0, k = 0, eval_c = 0, streak = 0;
        int          i_gap = 0, d_gap = 0, done_cnt = 0;
        logic [31:0] a = 0, wd = 0, exp_rd = 0;
        logic [3:0]  exp_sig;
        bit          act;
        for (int c = 0; c < 2000; c++) begin
            act     = busy && (c > t_g) && (c <= t_g + k);
            exp_sig = {act && !w, act && w, 2'b11};
            if (busy && c == t_g + k + 1) exp_sig[1:0] = own_d ? 2'b10 : 2'b01;
            total++;
            if ({ramREN, ramWEN, iwait, dwait} !== exp_sig) begin
                bad++; $display("FAIL rand_ctrl c%0d: got %b want %b", c, {ramREN, ramWEN, iwait, dwait}, exp_sig);
            end
            if (act) begin
                total++;
                if (ramaddr !== a || (w && ramstore !== wd)) begin
                    bad++; $display("FAIL rand_cmd c%0d: got a=%h s=%h want a=%h s=%h", c, ramaddr, ramstore, a, wd);
                end
            end
            if (busy && c == t_g + k + 1) begin
                if (!w) begin
                    total++;
                    if ((own_d ? dload : iload) !== exp_rd) begin
                        bad++; $display("FAIL rand_load c%0d: got %h want %h (%s)", c, own_d ? dload : iload,
                                        exp_rd, own_d ? "D" : "I");
                    end
                end else begin
                    mem[a] = wd;
                end
                if (own_d) begin d_req = 0; dREN = 0; dWEN = 0; d_gap = $urandom_range(0, 3); end
                else       begin i_req = 0; iREN = 0; i_gap = $urandom_range(0, 3); end
                busy = 0; eval_c = c + 1; done_cnt++;
            end
            if (busy && c > t_g) begin
                // the owner's inputs are ignored once granted
                if (own_d) begin daddr = $urandom; dstore = $urandom; end
                else       begin iaddr = $urandom; end
            end
            if (!i_req) begin
                if (i_gap > 0) i_gap--;
                else begin
                    i_req = 1; i_a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                    iREN = 1; iaddr = i_a;
                end
            end
            if (!d_req) begin
                if (d_gap > 0) d_gap--;
                else begin
                    d_req = 1; d_w = $urandom_range(0, 1); d_st = $urandom;
                    d_a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                    dREN = !d_w; dWEN = d_w; daddr = d_a; dstore = d_st;
                end
            end
            if (!busy && c >= eval_c && (i_req || d_req)) begin
                own_d = d_req && (!i_req || streak < MAXS);
                if (own_d) streak = i_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
                else       streak = 0;
                a      = own_d ? d_a : i_a;
                w      = own_d && d_w;
                wd     = d_st;
                exp_rd = mem_rd(a);
                k      = $urandom_range(1, 4);
                t_g    = c;
                busy   = 1;
            end
            if (busy && c > t_g && c <= t_g + k) begin
                ram_ready = (c == t_g + k);
                ramload   = (c == t_g + k && !w) ? exp_rd : $urandom;
            end else begin
                ram_ready = $urandom_range(0, 1);    // must be ignored outside ACCESS
                ramload   = $urandom;
            end
            tick();
        end
        ram_ready = 1'b0;
        total++;
        if (done_cnt < 100) begin
            bad++; $display("FAIL rand_progress: got %0d completions want >=100", done_cnt);
        end
        total++;
        if (bus_err !== 1'b1) begin
            bad++; $display("FAIL rand_sticky_err: got %b want 1", bus_err);
        end
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_contention();
        test_starvation();
        test_write();
        test_timeout();
        test_reset_mid();
        test_both_err();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
